lab2_proc_imm_encoder: RTL and testbench

//  Inverse of the datapath immediate generator: packs a 32-bit immediate into the imm bit fields
//  of a base RV32 instruction for a given imm_type. Streaming val/rdy unit with a 2-entry output

---
 rtl/lab2_proc_imm_pkg.sv | 73 +++++++
 rtl/lab2_proc_imm_enc_buf.sv | 49 ++++
 rtl/lab2_proc_imm_encoder.sv | 71 +++++++
 tb/tb_lab2_proc_imm_encoder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_proc_imm_pkg.sv
// Immediate-format helpers shared by the immediate encoder and the datapath immediate generator.
// imm_encode packs fields, imm_fits checks representability, and imm_decode reverses the packing.
package lab2_proc_imm_pkg;

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_S     = 3'd1;
  localparam logic [2:0] IMM_B     = 3'd2;
  localparam logic [2:0] IMM_U     = 3'd3;
  localparam logic [2:0] IMM_J     = 3'd4;
  localparam logic [2:0] IMM_SHAMT = 3'd5;

  function automatic logic [31:0] imm_encode(input logic [2:0]  imm_type,
                                             input logic [31:0] imm,
                                             input logic [31:0] inst);
    logic [31:0] enc;
    enc = inst;
    case (imm_type)
      IMM_I:     enc[31:20] = imm[11:0];
      IMM_S:     begin
                   enc[31:25] = imm[11:5];
                   enc[11:7]  = imm[4:0];
                 end
      IMM_B:     begin
                   enc[31]    = imm[12];
                   enc[30:25] = imm[10:5];
                   enc[11:8]  = imm[4:1];
                   enc[7]     = imm[11];
                 end
      IMM_U:     enc[31:12] = imm[31:12];
      IMM_J:     begin
                   enc[31]    = imm[20];
                   enc[30:21] = imm[10:1];
                   enc[20]    = imm[11];
                   enc[19:12] = imm[19:12];
                 end
      IMM_SHAMT: enc[24:20] = imm[4:0];
      default:   enc = inst;
    endcase
    return enc;
  endfunction

  function automatic logic imm_fits(input logic [2:0]  imm_type,
                                    input logic [31:0] imm);
    logic ok;
    ok = 1'b0;
    case (imm_type)
      IMM_I, IMM_S: ok = (imm[31:11] == '0) || (imm[31:11] == '1);
      IMM_B:        ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
      IMM_U:        ok = (imm[11:0] == '0);
      IMM_J:        ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
      IMM_SHAMT:    ok = (imm[31:5] == '0);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] imm_decode(input logic [2:0]  imm_type,
                                             input logic [31:0] inst);
    logic [31:0] imm;
    imm = '0;
    case (imm_type)
      IMM_I:     imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     imm = {inst[31:12], 12'b0};
      IMM_J:     imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_SHAMT: imm = {27'b0, inst[24:20]};
      default:   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/lab2_proc_imm_enc_buf.sv
// Two-entry val/rdy buffer with 1-bit wrapping pointers. Readiness comes from the registered
// occupancy only, so a dequeue from a full buffer frees a slot one cycle later.
module lab2_proc_imm_enc_buf #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_enq_val,
  output logic         o_enq_rdy,
  input  logic [W-1:0] i_enq_data,
  output logic         o_deq_val,
  input  logic         i_deq_rdy,
  output logic [W-1:0] o_deq_data
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_enq;
  logic         w_deq;

  assign o_enq_rdy  = (r_occ != 2'd2);
  assign o_deq_val  = (r_occ != 2'd0);
  assign o_deq_data = r_mem[r_rd_ptr];
  assign w_enq      = i_enq_val && o_enq_rdy;
  assign w_deq      = o_deq_val && i_deq_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= i_enq_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_deq) r_rd_ptr <= ~r_rd_ptr;
      case ({w_enq, w_deq})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/lab2_proc_imm_encoder.sv
// Packs an immediate into a base RV32 instruction. Flags immediates the format cannot represent.
// Define LAB2_PROC_IMM_ENC_SELFCHECK_EN to build the decode-back self-check (sticky chk_fail).
module lab2_proc_imm_encoder
  import lab2_proc_imm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [2:0]       in_imm_type,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_inst,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] xact_cnt,
  output logic             chk_fail
);

  logic             w_fits;
  logic             w_enq;
  logic [31:0]      w_enc_inst;
  logic [31:0]      w_buf_inst;
  logic [CNT_W-1:0] r_xact_cnt;

  assign w_fits     = imm_fits(in_imm_type, in_imm);
  assign w_enc_inst = imm_encode(in_imm_type, in_imm, in_inst);
  // Unrepresentable immediates pass the base instruction through untouched.
  assign w_buf_inst = w_fits ? w_enc_inst : in_inst;
  assign w_enq      = in_val && in_rdy;

  lab2_proc_imm_enc_buf #(
    .W (33)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_enq_val  (in_val),
    .o_enq_rdy  (in_rdy),
    .i_enq_data ({!w_fits, w_buf_inst}),
    .o_deq_val  (out_val),
    .i_deq_rdy  (out_rdy),
    .o_deq_data ({out_err, out_inst})
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_xact_cnt <= '0;
    else if (w_enq) r_xact_cnt <= r_xact_cnt + CNT_W'(1);
  end

  assign xact_cnt = r_xact_cnt;

`ifdef LAB2_PROC_IMM_ENC_SELFCHECK_EN
  logic        r_chk_fail;
  logic [31:0] w_dec_imm;

  assign w_dec_imm = imm_decode(in_imm_type, w_enc_inst);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_chk_fail <= 1'b0;
    else if (w_enq && w_fits && (w_dec_imm != in_imm)) r_chk_fail <= 1'b1;
  end

  assign chk_fail = r_chk_fail;
`else
  assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_lab2_proc_imm_encoder.sv
// Bench for lab2_proc_imm_encoder: directed format/handshake/reset cases, then randomized traffic
// scored against a bit-placement-table model with arithmetic range checks.
module tb_lab2_proc_imm_encoder;

  logic        clk;
  logic        reset_n;
  logic        in_val;
  logic        in_rdy;
  logic [2:0]  in_imm_type;
  logic [31:0] in_imm;
  logic [31:0] in_inst;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] xact_cnt;
  logic        chk_fail;

  int n_checks = 0;
  int n_errors = 0;

  lab2_proc_imm_encoder #(.CNT_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_imm_type (in_imm_type),
    .in_imm      (in_imm),
    .in_inst     (in_inst),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_inst    (out_inst),
    .out_err     (out_err),
    .xact_cnt    (xact_cnt),
    .chk_fail    (chk_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Which immediate bit lands in instruction bit b for a format (-1: bit belongs to base inst).
  function automatic int src_bit(input logic [2:0] t, input int b);
    case (t)
      3'd0: return (b >= 20) ? b - 20 : -1;
      3'd1: begin
        if (b >= 25) return b - 20;
        if (b >= 7 && b <= 11) return b - 7;
        return -1;
      end
      3'd2: begin
        if (b == 31) return 12;
        if (b >= 25) return b - 20;
        if (b >= 8 && b <= 11) return b - 7;
        if (b == 7) return 11;
        return -1;
      end
      3'd3: return (b >= 12) ? b : -1;
      3'd4: begin
        if (b == 31) return 20;
        if (b >= 21) return b - 20;
        if (b == 20) return 11;
        if (b >= 12) return b;
        return -1;
      end
      3'd5: return (b >= 20 && b <= 24) ? b - 20 : -1;
      default: return -1;
    endcase
  endfunction

  function automatic bit ref_fits(input logic [2:0] t, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (t)
      3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
      3'd2: return (v >= -4096) && (v <= 4095) && (v % 2 == 0);
      3'd3: return (imm % 4096) == 0;
      3'd4: return (v >= -(64'sd1 << 20)) && (v < (64'sd1 << 20)) && (v % 2 == 0);
      3'd5: return imm < 32;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [32:0] ref_out(input logic [2:0] t, input logic [31:0] imm,
                                          input logic [31:0] inst);
    logic [31:0] r;
    int s;
    if (!ref_fits(t, imm)) return {1'b1, inst};
    r = inst;
    for (int b = 0; b < 32; b++) begin
      s = src_bit(t, b);
      if (s >= 0) r[b] = imm[s];
    end
    return {1'b0, r};
  endfunction

  function automatic logic [31:0] legal_imm(input logic [2:0] t);
    int v;
    case (t)
      3'd0, 3'd1: v = int'($urandom_range(0, 4095)) - 2048;
      3'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      3'd3:       v = int'($urandom() & 32'hFFFFF000);
      3'd4:       v = (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2;
      default:    v = int'($urandom_range(0, 31));
    endcase
    return v;
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Single transfer into an empty buffer with consumer ready; checks latency-1 visibility.
  task automatic xfer1(input string tag, input logic [2:0] t, input logic [31:0] imm,
                       input logic [31:0] inst, input logic [31:0] exp_inst, input logic exp_err);
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    in_val = 1'b1; in_imm_type = t; in_imm = imm; in_inst = inst;
    @(negedge clk);
    check_eq({tag, "_in_rdy"}, in_rdy, 1);
    check_eq({tag, "_pre_val"}, out_val, 0);
    @(posedge clk);
    #1;
    in_val = 1'b0;
    check_eq({tag, "_val"}, out_val, 1);
    check_eq({tag, "_inst"}, out_inst, exp_inst);
    check_eq({tag, "_err"}, out_err, exp_err);
    @(posedge clk);
    #1;
    check_eq({tag, "_drained"}, out_val, 0);
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [31:0] imm;
    logic [31:0] inst;
  } stim_t;

  stim_t       stim_q[$];
  logic [32:0] exp_q[$];

  initial begin
    stim_t       s;
    logic [32:0] e;
    logic [32:0] ea, eb, ec;
    logic        cur_valid;
    int          idx;
    int          n_acc;
    int          cycles;
    logic        prev_stall;
    logic [32:0] prev_out;

    reset_n = 1'b0;
    in_val = 1'b0; out_rdy = 1'b0;
    in_imm_type = '0; in_imm = '0; in_inst = '0;
    #3;
    check_eq("rst_out_val", out_val, 0);
    check_eq("rst_xact_cnt", xact_cnt, 0);
    check_eq("rst_out_inst", out_inst, 0);
    check_eq("rst_out_err", out_err, 0);
    check_eq("rst_chk_fail", chk_fail, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_rdy", in_rdy, 1);

    xfer1("t1_I", 3'd0, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0);
    xfer1("t2_B", 3'd2, 32'h00000FFE, 32'h00000063, 32'h7E000FE3, 1'b0);
    xfer1("t3_U", 3'd3, 32'h12345000, 32'h00000037, 32'h12345037, 1'b0);
    xfer1("t3_Uerr", 3'd3, 32'h12345001, 32'h00000037, 32'h00000037, 1'b1);
    xfer1("t4_Jodd", 3'd4, 32'h00000003, 32'h0000006F, 32'h0000006F, 1'b1);
    xfer1("t4_type7", 3'd7, 32'h00000000, 32'h00000013, 32'h00000013, 1'b1);
    check_eq("dir_xact_cnt", xact_cnt, 6);

    // Backpressure: fill while stalled, then drain in order.
    apply_reset();
    ea = ref_out(3'd0, 32'd1, 32'h13);
    eb = ref_out(3'd0, 32'd2, 32'h13);
    ec = ref_out(3'd0, 32'd3, 32'h13);
    @(posedge clk);
    #1;
    in_val = 1'b1; in_imm_type = 3'd0; in_imm = 32'd1; in_inst = 32'h13;
    @(negedge clk);
    check_eq("bp_rdy_empty", in_rdy, 1);
    @(posedge clk);
    #1;
    in_imm = 32'd2;
    @(negedge clk);
    check_eq("bp_rdy_one", in_rdy, 1);
    check_eq("bp_head_a", out_inst, ea[31:0]);
    @(posedge clk);
    #1;
    in_imm = 32'd3;
    @(negedge clk);
    check_eq("bp_rdy_full", in_rdy, 0);
    @(posedge clk);
    #1;
    check_eq("bp_rdy_full2", in_rdy, 0);
    check_eq("bp_hold_a", out_inst, ea[31:0]);
    check_eq("bp_cnt2", xact_cnt, 2);
    out_rdy = 1'b1;
    @(negedge clk);
    check_eq("bp_rdy_no_bypass", in_rdy, 0);
    @(posedge clk);
    #1;
    check_eq("bp_rdy_rise", in_rdy, 1);
    check_eq("bp_out_b", out_inst, eb[31:0]);
    @(posedge clk);
    #1;
    in_val = 1'b0;
    check_eq("bp_out_c", out_inst, ec[31:0]);
    check_eq("bp_val_c", out_val, 1);
    @(posedge clk);
    #1;
    check_eq("bp_empty", out_val, 0);
    check_eq("bp_xact_cnt", xact_cnt, 3);

    // Asynchronous reset with two entries buffered.
    apply_reset();
    @(posedge clk);
    #1;
    in_val = 1'b1; in_imm_type = 3'd1; in_imm = 32'h7FF; in_inst = 32'h23;
    @(posedge clk);
    #1;
    in_imm = 32'hFFFFF800;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    check_eq("ar_pre_val", out_val, 1);
    check_eq("ar_pre_rdy", in_rdy, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_out_val", out_val, 0);
    check_eq("ar_xact_cnt", xact_cnt, 0);
    check_eq("ar_out_inst", out_inst, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Boundary immediates, including just-out-of-range ones and illegal type 6.
    stim_q.push_back('{3'd0, 32'h000007FF, 32'h00000013});
    stim_q.push_back('{3'd0, 32'hFFFFF800, 32'h00000013});
    stim_q.push_back('{3'd0, 32'h00000800, 32'h00000013});
    stim_q.push_back('{3'd1, 32'hFFFFF7FF, 32'h00000023});
    stim_q.push_back('{3'd2, 32'h00000FFE, 32'h00000063});
    stim_q.push_back('{3'd2, 32'hFFFFF000, 32'h00000063});
    stim_q.push_back('{3'd2, 32'h00001000, 32'h00000063});
    stim_q.push_back('{3'd4, 32'h000FFFFE, 32'h0000006F});
    stim_q.push_back('{3'd4, 32'hFFF00000, 32'h0000006F});
    stim_q.push_back('{3'd4, 32'h00100000, 32'h0000006F});
    stim_q.push_back('{3'd5, 32'h0000001F, 32'h00001013});
    stim_q.push_back('{3'd5, 32'h00000020, 32'h00001013});
    stim_q.push_back('{3'd6, 32'h00000000, 32'h00000013});
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 1000; k++) begin
        s.t = 3'(t);
        s.imm = legal_imm(3'(t));
        s.inst = $urandom();
        stim_q.push_back(s);
      end
    end
    for (int k = 0; k < 200; k++) begin
      s.t = 3'($urandom_range(0, 7));
      s.imm = $urandom();
      s.inst = $urandom();
      stim_q.push_back(s);
    end

    cur_valid = 1'b0;
    idx = 0;
    n_acc = 0;
    cycles = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    while ((idx < stim_q.size() || cur_valid || exp_q.size() != 0) && cycles < 60000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (!cur_valid && idx < stim_q.size() && $urandom_range(0, 3) != 0) begin
        in_imm_type = stim_q[idx].t;
        in_imm = stim_q[idx].imm;
        in_inst = stim_q[idx].inst;
        idx++;
        cur_valid = 1'b1;
      end
      in_val = cur_valid;
      out_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall) begin
        check_eq("stall_val", out_val, 1);
        check_eq("stall_inst", out_inst, prev_out[31:0]);
        check_eq("stall_err", out_err, prev_out[32]);
      end
      if (in_val && in_rdy) begin
        exp_q.push_back(ref_out(in_imm_type, in_imm, in_inst));
        n_acc++;
        cur_valid = 1'b0;
      end
      if (out_val && out_rdy) begin
        if (exp_q.size() == 0) begin
          check_eq("rand_unexpected", out_val, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rand_inst", out_inst, e[31:0]);
          check_eq("rand_err", out_err, e[32]);
        end
      end
      prev_stall = out_val && !out_rdy;
      prev_out = {out_err, out_inst};
    end
    in_val = 1'b0;
    check_eq("rand_all_sent", idx, stim_q.size());
    check_eq("rand_sb_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    check_eq("rand_xact_cnt", xact_cnt, n_acc & 32'hFFFF);
    check_eq("rand_chk_fail", chk_fail, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
